// File: rtl/aes_enc_pkg.sv
// Shared definitions for the byte-serial AES encryption round engine:
// FSM encoding, ShiftRows-folded byte addressing, Te0 rotation amounts and
// a GF(2^8) doubling helper used to build the forward T-box.
package aes_enc_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_COL_W   = 32;

    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_LOOKUP = 2'd1,
        FSM_DRAIN  = 2'd2,
        FSM_DONE   = 2'd3
    } aes_fsm_e;

    // Source byte index for lookup step cnt = {c, r}: byte s[r, (c+r) mod 4],
    // i.e. 4*((c+r) mod 4) + r. Entry [k] belongs to step k.
    localparam logic [15:0][3:0] SRC_BYTE_IDX = {
        4'd11, 4'd6,  4'd1,  4'd12,
        4'd7,  4'd2,  4'd13, 4'd8,
        4'd3,  4'd14, 4'd9,  4'd4,
        4'd15, 4'd10, 4'd5,  4'd0
    };

    // Te_r = ror(Te0, 8r): rotate-right amount for row r.
    localparam logic [3:0][4:0] TE_ROT = {5'd24, 5'd16, 5'd8, 5'd0};

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // 32-bit rotate right.
    function automatic logic [31:0] ror32(input logic [31:0] w, input logic [4:0] amt);
        logic [63:0] d;
        d = {w, w} >> amt;
        return d[31:0];
    endfunction

endpackage

// File: rtl/tboxe0.sv
// Forward T-box ROM Te0: 256 x 32, synchronous registered read.
// Te0[x] = {2*S[x], S[x], S[x], 3*S[x]}, most significant byte first.
module tboxe0
    import aes_enc_pkg::*;
(
    input  logic        clk,
    input  logic [7:0]  a,
    output logic [31:0] q
);

    // AES S-box, entry 0 first.
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [31:0] rom [256];

    genvar gi;
    generate
        for (gi = 0; gi < 256; gi++) begin : g_rom
            localparam logic [7:0] S1 = SBOX[gi];
            localparam logic [7:0] S2 = gf_xtime(S1);
            assign rom[gi] = {S2, S1, S1, S2 ^ S1};
        end
    endgenerate

    // Registered read: data appears one cycle after the address.
    always_ff @(posedge clk) begin
        q <= rom[a];
    end

endmodule

// File: rtl/aes_enc_round_serial.sv
// Byte-serial AES forward round: SubBytes, ShiftRows, MixColumns, AddRoundKey
// computed with one Te0 lookup per cycle and four column accumulators.
// Optional feature macro: AES_ENC_LASTROUND_EN (honour 'last' = skip MixColumns).
module aes_enc_round_serial
    import aes_enc_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] state_in,
    input  logic [AES_BLOCK_W-1:0] rkey,
    input  logic                   last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] state_out
);

    localparam logic [1:0] ST_IDLE   = FSM_IDLE;
    localparam logic [1:0] ST_LOOKUP = FSM_LOOKUP;
    localparam logic [1:0] ST_DRAIN  = FSM_DRAIN;
    localparam logic [1:0] ST_DONE   = FSM_DONE;

    logic [1:0]             state_reg;
    logic [3:0]             cnt_reg;
    logic [AES_BLOCK_W-1:0] st_reg;
    logic [AES_BLOCK_W-1:0] key_reg;
    logic [AES_BLOCK_W-1:0] out_reg;
    logic                   out_valid_reg;
    logic [AES_COL_W-1:0]   acc_reg  [4];
    logic [AES_COL_W-1:0]   acc_next [4];
    logic                   tag_vld_reg;
    logic [3:0]             tag_reg;

    logic [15:0][7:0]       st_bytes;
    logic [7:0]             rom_addr;
    logic [31:0]            rom_q;
    logic [1:0]             tag_col;
    logic [1:0]             tag_row;
    logic [31:0]            contrib;
    logic [AES_BLOCK_W-1:0] drain_word;
    logic                   accept;

    assign accept    = (state_reg == ST_IDLE) && in_valid;
    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = out_valid_reg;
    assign state_out = out_reg;

    // ShiftRows is folded into the addressing: step {c,r} reads s[r,(c+r) mod 4].
    assign st_bytes = st_reg;
    assign rom_addr = st_bytes[4'd15 - SRC_BYTE_IDX[cnt_reg]];

    tboxe0 u_tbox (
        .clk (clk),
        .a   (rom_addr),
        .q   (rom_q)
    );

    assign tag_col = tag_reg[3:2];
    assign tag_row = tag_reg[1:0];

`ifdef AES_ENC_LASTROUND_EN
    logic        last_reg;
    logic [31:0] sbox_word;

    // Final round: bare S-box byte (Te0 byte 2) placed at row r, other rows zero.
    assign sbox_word = {rom_q[23:16], 24'd0} >> TE_ROT[tag_row];
    assign contrib   = last_reg ? sbox_word : ror32(rom_q, TE_ROT[tag_row]);

    // 'last' is captured only at accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_reg <= 1'b0;
        end else if (accept) begin
            last_reg <= last;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;
    assign contrib     = ror32(rom_q, TE_ROT[tag_row]);
`endif

    // Each column accumulator picks up the word whose pipelined tag names it.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            localparam logic [1:0] COL = 2'(gi);
            assign acc_next[gi] = acc_reg[gi] ^ ((tag_vld_reg && (tag_col == COL)) ? contrib : '0);
        end
    endgenerate

    // Column 0 occupies the most significant word; round key is applied last.
    assign drain_word = {acc_next[0], acc_next[1], acc_next[2], acc_next[3]} ^ key_reg;

    // Control FSM, input capture and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            st_reg        <= '0;
            key_reg       <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        st_reg    <= state_in;
                        key_reg   <= rkey;
                        cnt_reg   <= 4'd0;
                        state_reg <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    cnt_reg <= cnt_reg + 4'd1;
                    if (cnt_reg == 4'd15) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    out_reg       <= drain_word;
                    out_valid_reg <= 1'b1;
                    state_reg     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // ROM-latency tag pipeline and column accumulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld_reg <= 1'b0;
            tag_reg     <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                acc_reg[i] <= '0;
            end
        end else begin
            tag_vld_reg <= (state_reg == ST_LOOKUP);
            tag_reg     <= cnt_reg;
            if (accept) begin
                for (int i = 0; i < 4; i++) begin
                    acc_reg[i] <= '0;
                end
            end else if ((state_reg == ST_LOOKUP) || (state_reg == ST_DRAIN)) begin
                for (int i = 0; i < 4; i++) begin
                    acc_reg[i] <= acc_next[i];
                end
            end
        end
    end

endmodule

// File: doc/aes_enc_round_serial.md
# aes_enc_round_serial

Byte-serial AES forward (encryption) round engine. It is the encrypt-side counterpart of the existing inverse-T-box decryption datapath. It takes a 128-bit state and a 128-bit round key and computes one full AES round (SubBytes, ShiftRows, MixColumns, AddRoundKey) or a final round (no MixColumns). It uses a single synchronous forward T-box ROM read once per cycle. It sits behind the Nios II custom-instruction/Avalon glue and trades throughput for area: one ROM, one 32-bit accumulator path.

## Interface
- No parameters.
- `clk` in 1: single clock, all flops rising-edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: input state/key/last valid.
- `in_ready` out 1: block idle and accepting.
- `state_in` in 128: AES state. Byte 0 is at [127:120]. Column-major: s[r,c] = byte 4c+r.
- `rkey` in 128: round key, same byte order.
- `last` in 1: 1 = final round (omit MixColumns).
- `out_valid` out 1: `state_out` valid.
- `out_ready` in 1: consumer accepts result.
- `state_out` out 128: round result, same byte order.

## Operation
- FSM states: IDLE, LOOKUP, DRAIN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: register `state_in`, `rkey` and `last`, clear the 4×32 column accumulators, set cnt=0, go to LOOKUP.
- **LOOKUP** (cnt 0..15)
  - Address ROM with byte s[r, (c+r) mod 4], where c=cnt[3:2] and r=cnt[1:0] (ShiftRows folded into addressing).
  - cnt 15 → DRAIN.
- **Accumulate**
  - ROM data returns one cycle after its address.
  - For a full round, XOR the word rotated right by 8·r into accumulator c. Te_r = ror(Te0, 8r).
  - For a last round, take the S-box byte q[23:16] and place it at row r of accumulator c, all other rows zero.
  - The pipelined (c,r) tag travels with the ROM latency.
- **DRAIN**
  - Accumulate the final (cnt 15) word.
  - XOR `rkey` into all columns.
  - Load `state_out`, assert `out_valid`, go to DONE.
- **DONE**
  - Hold `out_valid` and `state_out` until `out_ready`.
  - Then drop `out_valid` and go to IDLE.
- **ROM contents:** Te0[x] = {2·S[x], S[x], S[x], 3·S[x]}, GF(2^8) with polynomial 0x11B, MSB byte first. Example: Te0[0x00]=32'hc66363a5.
- `in_valid` outside IDLE is ignored. Upstream must hold its data until `in_ready`.

## Timing
- Reset values: FSM=IDLE, `in_ready`=1, `out_valid`=0, `state_out`=0, cnt=0, accumulators=0.
- Accept at edge E0 → `out_valid` rises after edge E17. Latency is 17 cycles.
- Minimum initiation interval is 19 cycles: 17 cycles of latency, plus 1 DONE cycle with `out_ready`=1, plus 1 IDLE accept cycle.
- `out_ready` held high in DONE: exactly one transfer, with `out_valid` low on the next cycle.
- Reset asserted mid-LOOKUP, DRAIN or DONE: immediately abort to the reset values. The partial result is discarded and never presented.
- `last` is sampled only at accept. Changes during LOOKUP have no effect.

## Configuration
- `AES_ENC_LASTROUND_EN` defined: `last` is honoured as described.
- `AES_ENC_LASTROUND_EN` undefined:
  - `last` is ignored and every operation is a full round.
  - The byte-extract path and the registered `last` flop are removed.
  - The port remains present.

## Structure
- Shared package `aes_enc_pkg`:
  - FSM state enum.
  - Byte-index helper constants (row/column shift map).
  - Te0 rotation amounts.
  - `AES_BLOCK_W`=128, `AES_COL_W`=32.
- Sub-module `tboxe0`: synchronous 256×32 forward T-box ROM with interface `clk`, `a[7:0]`, registered `q[31:0]`. It mirrors the decryption T-box ROM style.

## Test plan
- **Zero full round:** `state_in`=0, `rkey`=0, `last`=0 → `state_out`=128'h63636363636363636363636363636363 exactly 17 cycles after accept.
- **FIPS-197 App. B round 1:** `state_in`=193de3bea0f4e22b9ac68d2ae9f84808, `rkey`=a0fafe1788542cb123a339392a6c7605, `last`=0 → a49c7ff2689f352b6b5bea43026a5049.
- **FIPS-197 final round:** `state_in`=eb598b1b402ea1c3f23813421e84e7d2, `rkey`=d014f9a8c9ee2589e13f0cc8b6630ca6, `last`=1 → 3925841d02dc09fbdc118597196a0b32. With the macro undefined this must not match the last-round result; instead it equals the full-round result.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid` → output stable, `in_ready`=0. New `in_valid` pulses are ignored. Release → one transfer, then `in_ready`=1.
- **Reset mid-operation:** pulse `reset` at cnt=7 → `out_valid` stays 0 and `in_ready`=1 after reset. A following zero-state request returns all-0x63 with nominal latency.
- **Back-to-back:** two requests with `out_ready` tied high → results in order, accept edges 19 cycles apart.
